// File: rtl/sram_line_streamer_pkg.sv
// Shared definitions for the SRAM line streamer.
//   ch_state_e      : per-channel sequencing state (2 bits)
//   WPL / WIDX_W    : words per line and word-index width at the default
//                     240-bit line / 48-bit word geometry
//   LINE_BUF_DEPTH  : lines each channel may hold (buffered + in flight)
//   words_per_line / idx_width : helpers used when the modules are
//                     parametrised away from the defaults
package sram_line_streamer_pkg;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_FETCH = 2'd1,
        CH_DRAIN = 2'd2,
        CH_DONE  = 2'd3
    } ch_state_e;

    localparam int DEF_LINE_W     = 240;
    localparam int DEF_WORD_W     = 48;
    localparam int WPL            = DEF_LINE_W / DEF_WORD_W;
    localparam int WIDX_W         = $clog2(WPL);
    localparam int LINE_BUF_DEPTH = 2;

    function automatic int words_per_line(input int line_w, input int word_w);
        return line_w / word_w;
    endfunction

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sram_line_channel.sv
// One streaming channel: fetches a run of SRAM lines, holds up to two in a
// FIFO and emits each line as LSB-first words over valid/ready.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_start               accepted start (already qualified by the top)
//   i_base, i_count       first line address, number of lines
//   i_all_done            every channel is in DONE; return to IDLE
//   o_state               current channel state
//   o_sram_re/o_sram_addr read request; data returns one cycle later
//   i_sram_rdata          line data
//   o_word/o_valid/o_last output word, valid, final word of final line
//   i_ready               consumer accepts
//
// state    | meaning
// ---------+--------------------------------------------
// CH_IDLE  | waiting for start
// CH_FETCH | issuing reads and draining words
// CH_DRAIN | all reads issued, buffered lines streaming
// CH_DONE  | finished, waiting for the other channels
module sram_line_channel
    import sram_line_streamer_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LINE_W = 240,
    parameter int WORD_W = 48
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_count,
    input  logic              i_all_done,
    output ch_state_e         o_state,
    output logic              o_sram_re,
    output logic [ADDR_W-1:0] o_sram_addr,
    input  logic [LINE_W-1:0] i_sram_rdata,
    output logic [WORD_W-1:0] o_word,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_last
);
    localparam int N_WORDS = words_per_line(LINE_W, WORD_W);
    localparam int IDX_W   = idx_width(N_WORDS);

    ch_state_e         r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, r_issue_left, r_lines_left;
    logic              r_inflight;
    logic [LINE_W-1:0] r_mem [LINE_BUF_DEPTH];
    logic              r_wptr, r_rptr;
    logic [1:0]        r_occ;
    logic [IDX_W-1:0]  r_widx;
    logic              w_re, w_push, w_pop, w_valid, w_word_end, w_last_line;
    logic [WORD_W-1:0] w_word;

    assign w_valid     = (r_occ != 2'd0);
    assign w_word_end  = (r_widx == IDX_W'(N_WORDS - 1));
    assign w_pop       = w_valid && i_ready && w_word_end;
    assign w_push      = r_inflight;
    // Head of the FIFO is the oldest unpopped line, so it is the final line
    // exactly when one line remains to be popped.
    assign w_last_line = (r_lines_left == ADDR_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        // Buffered lines plus the read in flight must stay below the depth.
        w_re = (r_state == CH_FETCH) &&
               ((r_occ + {1'b0, r_inflight}) < 2'(LINE_BUF_DEPTH));
        unique case (r_state)
            CH_IDLE:  if (i_start) w_state_nxt = (i_count != '0) ? CH_FETCH : CH_DONE;
            CH_FETCH: if (w_re && (r_issue_left == ADDR_W'(1))) w_state_nxt = CH_DRAIN;
            CH_DRAIN: if (w_pop && w_last_line) w_state_nxt = CH_DONE;
            CH_DONE:  if (i_all_done) w_state_nxt = CH_IDLE;
            default:  w_state_nxt = CH_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= CH_IDLE;
            r_addr       <= '0;
            r_issue_left <= '0;
            r_lines_left <= '0;
            r_inflight   <= 1'b0;
            r_wptr       <= 1'b0;
            r_rptr       <= 1'b0;
            r_occ        <= 2'd0;
            r_widx       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_re;
            if ((r_state == CH_IDLE) && i_start) begin
                r_addr       <= i_base;
                r_issue_left <= i_count;
                r_lines_left <= i_count;
            end else begin
                if (w_re) begin
                    r_addr       <= r_addr + ADDR_W'(1);
                    r_issue_left <= r_issue_left - ADDR_W'(1);
                end
                if (w_pop) r_lines_left <= r_lines_left - ADDR_W'(1);
            end
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
            if (w_valid && i_ready) r_widx <= w_word_end ? '0 : r_widx + IDX_W'(1);
        end
    end

    // Line storage needs no reset; nothing reads it while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_sram_rdata;
    end

    always_comb begin
        w_word = '0;
        for (int k = 0; k < N_WORDS; k++) begin
            if (r_widx == IDX_W'(k)) w_word = r_mem[r_rptr][k*WORD_W +: WORD_W];
        end
    end

    // All outputs come from registers only, so valid never follows ready.
    assign o_state     = r_state;
    assign o_sram_re   = w_re;
    assign o_sram_addr = r_addr;
    assign o_valid     = w_valid;
    assign o_word      = w_valid ? w_word : '0;
    assign o_last      = w_valid && w_word_end && w_last_line;

endmodule

// File: rtl/sram_line_streamer.sv
// NUM_CH independent SRAM line streamers with shared start/busy/done.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_start                        one-cycle start; accepted only when all channels idle
//   i_base_addr, i_line_count      per-channel base/count, channel c at [c*ADDR_W +: ADDR_W]
//   o_sram_re, o_sram_addr         per-channel read request
//   i_sram_rdata                   per-channel line data, one cycle after o_sram_re
//   o_word_out, o_word_valid,
//   i_word_ready, o_word_last      per-channel word stream
//   o_busy                         run in progress
//   o_done                         one-cycle pulse when every channel has finished
module sram_line_streamer
    import sram_line_streamer_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 8,
    parameter int LINE_W = 240,
    parameter int WORD_W = 48
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [NUM_CH*ADDR_W-1:0] i_base_addr,
    input  logic [NUM_CH*ADDR_W-1:0] i_line_count,
    output logic [NUM_CH-1:0]        o_sram_re,
    output logic [NUM_CH*ADDR_W-1:0] o_sram_addr,
    input  logic [NUM_CH*LINE_W-1:0] i_sram_rdata,
    output logic [NUM_CH*WORD_W-1:0] o_word_out,
    output logic [NUM_CH-1:0]        o_word_valid,
    input  logic [NUM_CH-1:0]        i_word_ready,
    output logic [NUM_CH-1:0]        o_word_last,
    output logic                     o_busy,
    output logic                     o_done
);
    ch_state_e         w_state [NUM_CH];
    logic [NUM_CH-1:0] w_is_idle, w_is_done;
    logic              w_all_idle, w_all_done, w_start_acc;

    // Requiring every channel idle also drops a start in the done cycle,
    // when the channels are still in DONE.
    assign w_all_idle  = &w_is_idle;
    assign w_all_done  = &w_is_done;
    assign w_start_acc = i_start && w_all_idle;
    assign o_busy      = !w_all_idle && !w_all_done;
    assign o_done      = w_all_done;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_is_idle[c] = (w_state[c] == CH_IDLE);
        assign w_is_done[c] = (w_state[c] == CH_DONE);

        sram_line_channel #(
            .ADDR_W (ADDR_W),
            .LINE_W (LINE_W),
            .WORD_W (WORD_W)
        ) u_ch (
            .i_clk        (i_clk),
            .i_rst_n      (i_rst_n),
            .i_start      (w_start_acc),
            .i_base       (i_base_addr[c*ADDR_W +: ADDR_W]),
            .i_count      (i_line_count[c*ADDR_W +: ADDR_W]),
            .i_all_done   (w_all_done),
            .o_state      (w_state[c]),
            .o_sram_re    (o_sram_re[c]),
            .o_sram_addr  (o_sram_addr[c*ADDR_W +: ADDR_W]),
            .i_sram_rdata (i_sram_rdata[c*LINE_W +: LINE_W]),
            .o_word       (o_word_out[c*WORD_W +: WORD_W]),
            .o_valid      (o_word_valid[c]),
            .i_ready      (i_word_ready[c]),
            .o_last       (o_word_last[c])
        );
    end

endmodule

// File: tb/tb_sram_line_streamer.sv
module tb_sram_line_streamer;
    localparam int NUM_CH = 2;
    localparam int ADDR_W = 8;
    localparam int LINE_W = 240;
    localparam int WORD_W = 48;
    localparam int WPL    = LINE_W / WORD_W;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start = 1'b0;
    logic [NUM_CH*ADDR_W-1:0] base_addr = '0;
    logic [NUM_CH*ADDR_W-1:0] line_count = '0;
    logic [NUM_CH-1:0]        sram_re;
    logic [NUM_CH*ADDR_W-1:0] sram_addr;
    logic [NUM_CH*LINE_W-1:0] sram_rdata = '0;
    logic [NUM_CH*WORD_W-1:0] word_out;
    logic [NUM_CH-1:0]        word_valid;
    logic [NUM_CH-1:0]        word_ready = '1;
    logic [NUM_CH-1:0]        word_last;
    logic                     busy, done;

    always #5 clk = ~clk;

    sram_line_streamer #(
        .NUM_CH (NUM_CH), .ADDR_W (ADDR_W), .LINE_W (LINE_W), .WORD_W (WORD_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_base_addr  (base_addr),
        .i_line_count (line_count),
        .o_sram_re    (sram_re),
        .o_sram_addr  (sram_addr),
        .i_sram_rdata (sram_rdata),
        .o_word_out   (word_out),
        .o_word_valid (word_valid),
        .i_word_ready (word_ready),
        .o_word_last  (word_last),
        .o_busy       (busy),
        .o_done       (done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural SRAM: random contents, data one cycle after the read.
    logic [LINE_W-1:0] mem [NUM_CH][256];
    always @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (sram_re[c]) sram_rdata[c*LINE_W +: LINE_W] <= mem[c][sram_addr[c*ADDR_W +: ADDR_W]];
            else            sram_rdata[c*LINE_W +: LINE_W] <= '1;
        end
    end

    int ready_mode = 0;  // 0: always ready, 1: random, 2: never
    always @(posedge clk) begin
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            case (ready_mode)
                0:       word_ready[c] = 1'b1;
                1:       word_ready[c] = 1'($urandom_range(0, 1));
                default: word_ready[c] = 1'b0;
            endcase
        end
    end

    // Reference model: expected word stream per channel plus line bookkeeping.
    logic [WORD_W-1:0] q_word [NUM_CH][$];
    bit                q_last [NUM_CH][$];
    logic [ADDR_W-1:0] q_addr [NUM_CH][$];
    int                q_iss  [NUM_CH][$];
    logic [ADDR_W-1:0] addr_log [NUM_CH][$];
    int n_count [NUM_CH], n_issued [NUM_CH], n_popped [NUM_CH], n_capt [NUM_CH], n_words [NUM_CH];
    int first_re [NUM_CH], first_val [NUM_CH], last_cyc [NUM_CH];
    bit running = 1'b0;
    int run_start_cyc = 0, done_due = -1, acc_cyc = 0, done_cyc = -1, done_pulses = 0;

    always @(negedge clk) begin
        bit exp_done, exp_re, exp_valid, xfer, can_acc, allz, empty;
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] ln;
        cyc++;
        if (!rst_n) begin
            chk("reset_ctrl", 64'({busy, done, sram_re, word_valid, word_last}), 64'd0);
            chk("reset_data", 64'({|word_out, |sram_addr}), 64'd0);
            running = 1'b0;
            done_due = -1;
            for (int c = 0; c < NUM_CH; c++) begin
                q_word[c].delete(); q_last[c].delete(); q_addr[c].delete(); q_iss[c].delete();
                n_count[c] = 0; n_issued[c] = 0; n_popped[c] = 0; n_capt[c] = 0; n_words[c] = 0;
            end
        end else begin
            can_acc = !running;
            xfer = 1'b0;
            exp_done = (cyc == done_due);
            if (done) begin done_cyc = cyc; done_pulses++; end
            chk("done", 64'(done), 64'(exp_done));
            chk("busy", 64'(busy), 64'(running && cyc >= run_start_cyc && !exp_done));
            for (int c = 0; c < NUM_CH; c++) begin
                while (q_iss[c].size() > 0 && q_iss[c][0] <= cyc - 2) begin
                    void'(q_iss[c].pop_front());
                    n_capt[c]++;
                end
                exp_re = running && cyc >= run_start_cyc && n_issued[c] < n_count[c] &&
                         (n_issued[c] - n_popped[c]) < 2;
                chk("sram_re", 64'(sram_re[c]), 64'(exp_re));
                if (sram_re[c] && exp_re) begin
                    chk("sram_addr", 64'(sram_addr[c*ADDR_W +: ADDR_W]), 64'(q_addr[c][0]));
                    if (n_issued[c] == 0) first_re[c] = cyc;
                    addr_log[c].push_back(sram_addr[c*ADDR_W +: ADDR_W]);
                    void'(q_addr[c].pop_front());
                    q_iss[c].push_back(cyc);
                    n_issued[c]++;
                end
                exp_valid = n_capt[c] > n_popped[c];
                chk("word_valid", 64'(word_valid[c]), 64'(exp_valid));
                if (word_valid[c] && first_val[c] < 0) first_val[c] = cyc;
                if (word_valid[c] && exp_valid) begin
                    chk("word_out", 64'(word_out[c*WORD_W +: WORD_W]), 64'(q_word[c][0]));
                    chk("word_last", 64'(word_last[c]), 64'(q_last[c][0]));
                    if (word_ready[c]) begin
                        if (word_last[c]) last_cyc[c] = cyc;
                        void'(q_word[c].pop_front());
                        void'(q_last[c].pop_front());
                        n_words[c]++;
                        if (n_words[c] % WPL == 0) n_popped[c]++;
                        xfer = 1'b1;
                    end
                end
            end
            if (exp_done) running = 1'b0;
            empty = 1'b1;
            for (int c = 0; c < NUM_CH; c++) if (q_word[c].size() != 0) empty = 1'b0;
            if (xfer && running && empty) done_due = cyc + 1;
            if (start && can_acc) begin
                allz = 1'b1;
                running = 1'b1;
                acc_cyc = cyc;
                run_start_cyc = cyc + 1;
                done_due = -1;
                for (int c = 0; c < NUM_CH; c++) begin
                    n_count[c] = int'(line_count[c*ADDR_W +: ADDR_W]);
                    n_issued[c] = 0; n_popped[c] = 0; n_capt[c] = 0; n_words[c] = 0;
                    first_re[c] = -1; first_val[c] = -1; last_cyc[c] = -1;
                    q_word[c].delete(); q_last[c].delete(); q_addr[c].delete(); q_iss[c].delete();
                    addr_log[c].delete();
                    if (n_count[c] != 0) allz = 1'b0;
                    for (int l = 0; l < n_count[c]; l++) begin
                        a = base_addr[c*ADDR_W +: ADDR_W] + ADDR_W'(l);
                        q_addr[c].push_back(a);
                        ln = mem[c][a];
                        for (int k = 0; k < WPL; k++) begin
                            q_word[c].push_back(ln[k*WORD_W +: WORD_W]);
                            q_last[c].push_back(l == n_count[c] - 1 && k == WPL - 1);
                        end
                    end
                end
                if (allz) done_due = cyc + 1;
            end
        end
    end

    task automatic do_start(input logic [7:0] b0, input logic [7:0] c0,
                            input logic [7:0] b1, input logic [7:0] c1);
        @(posedge clk); #2;
        base_addr = {b1, b0};
        line_count = {c1, c0};
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (running && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("idle_timeout", 64'(running), 64'd0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        logic [255:0] t;
        int dp;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int a = 0; a < 256; a++) begin
                for (int j = 0; j < 8; j++) t[j*32 +: 32] = $urandom;
                mem[c][a] = t[LINE_W-1:0];
            end
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("idle_busy", 64'({busy, done, word_valid}), 64'd0);

        // Single line per channel, latency pinned to literal cycle offsets.
        ready_mode = 0;
        do_start(8'h10, 8'd1, 8'h20, 8'd1);
        wait_idle(100);
        chk("t1_re_lat0", 64'(first_re[0] - acc_cyc), 64'd1);
        chk("t1_re_lat1", 64'(first_re[1] - acc_cyc), 64'd1);
        chk("t1_addr0", 64'(addr_log[0][0]), 64'h10);
        chk("t1_addr1", 64'(addr_log[1][0]), 64'h20);
        chk("t1_valid_lat", 64'(first_val[0] - acc_cyc), 64'd3);
        chk("t1_last_lat0", 64'(last_cyc[0] - acc_cyc), 64'd7);
        chk("t1_last_lat1", 64'(last_cyc[1] - acc_cyc), 64'd7);
        chk("t1_done_lat", 64'(done_cyc - acc_cyc), 64'd8);

        // Address wrap and gapless streaming.
        do_start(8'hFE, 8'd3, 8'h00, 8'd0);
        wait_idle(200);
        chk("t2_nreads", 64'(addr_log[0].size()), 64'd3);
        chk("t2_addr_a", 64'(addr_log[0][0]), 64'hFE);
        chk("t2_addr_b", 64'(addr_log[0][1]), 64'hFF);
        chk("t2_addr_c", 64'(addr_log[0][2]), 64'h00);
        chk("t2_words", 64'(n_words[0]), 64'd15);
        chk("t2_gapless", 64'(last_cyc[0] - first_val[0]), 64'd14);

        // Backpressure: only two reads before the stall.
        ready_mode = 2;
        do_start(8'h30, 8'd4, 8'h00, 8'd0);
        repeat (20) @(posedge clk);
        chk("t3_stall_reads", 64'(n_issued[0]), 64'd2);
        chk("t3_stall_words", 64'(n_words[0]), 64'd0);
        ready_mode = 0;
        wait_idle(300);
        chk("t3_words", 64'(n_words[0]), 64'd20);

        // Empty channel alongside a two-line channel.
        do_start(8'h50, 8'd0, 8'h60, 8'd2);
        wait_idle(200);
        chk("t4_words0", 64'(n_words[0]), 64'd0);
        chk("t4_words1", 64'(n_words[1]), 64'd10);
        chk("t4_done_after", 64'(done_cyc - last_cyc[1]), 64'd1);

        // Start re-pulsed mid-run is ignored.
        do_start(8'h40, 8'd2, 8'h44, 8'd2);
        repeat (2) @(posedge clk);
        do_start(8'h80, 8'd5, 8'h88, 8'd5);
        wait_idle(300);
        chk("t5_addr0", 64'(addr_log[0][0]), 64'h40);
        chk("t5_words0", 64'(n_words[0]), 64'd10);
        chk("t5_words1", 64'(n_words[1]), 64'd10);

        // Asynchronous reset mid-run.
        ready_mode = 1;
        do_start(8'h70, 8'd5, 8'h90, 8'd5);
        repeat (8) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_async_ctrl", 64'({busy, done, sram_re, word_valid, word_last}), 64'd0);
        chk("t6_async_data", 64'({|word_out, |sram_addr}), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        ready_mode = 0;
        dp = done_pulses;
        repeat (30) @(posedge clk);
        chk("t6_no_done", 64'(done_pulses - dp), 64'd0);

        // Randomised runs.
        for (int it = 0; it < 10; it++) begin
            ready_mode = int'($urandom_range(0, 1));
            do_start(8'($urandom), 8'($urandom_range(0, 6)), 8'($urandom), 8'($urandom_range(0, 6)));
            if ($urandom_range(0, 1) == 1) begin
                repeat (3) @(posedge clk);
                if (running) do_start(8'($urandom), 8'($urandom_range(1, 6)), 8'($urandom), 8'd3);
            end
            wait_idle(2000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
